// File: rtl/gpio_check_pkg.sv
// Shared definitions for the GPIO toggle checker: FSM state encoding and
// the fail_code values reported to the bench / firmware.
package gpio_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_SHORT   = 2'd2;
    localparam logic [1:0] FC_LONG    = 2'd3;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a registered
// any-edge detector; edge_pulse lags a pin change by SYNC_STAGES+1 clocks.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic pin_in,
    output logic level,
    output logic edge_pulse
);

    // Fewer than two stages is not a synchronizer; clamp rather than break.
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [NS-1:0] sync_q, sync_d;
    logic          prev_q, prev_d;
    logic          edge_q, edge_d;
    logic          sync_out;

    assign sync_out = sync_q[NS-1];

    always_comb begin
        sync_d = {sync_q[NS-2:0], pin_in};
        prev_d = sync_out;
        edge_d = sync_out ^ prev_q;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign level      = sync_out;
    assign edge_pulse = edge_q;

endmodule

// File: rtl/gpio_toggle_checker.sv
// Checks that a GPIO pin toggles a required number of times with every
// half-period inside [min_half, max_half] and a bounded wait for the first edge.
module gpio_toggle_checker
    import gpio_check_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EDGE_W      = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              pin_in,
    input  logic              start,
    input  logic [EDGE_W-1:0] exp_edges,
    input  logic [CNT_W-1:0]  min_half,
    input  logic [CNT_W-1:0]  max_half,
    input  logic [CNT_W-1:0]  timeout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [EDGE_W-1:0] edge_count,
    output logic [CNT_W-1:0]  last_half
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EDGE_W-1:0] EDGE_ONE = {{(EDGE_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [EDGE_W-1:0] sat_inc_edge(input logic [EDGE_W-1:0] v);
        return (&v) ? v : v + EDGE_ONE;
    endfunction

    logic pin_level_unused;
    logic pin_edge;

    gpio_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock      (clock),
        .resetb     (resetb),
        .pin_in     (pin_in),
        .level      (pin_level_unused),
        .edge_pulse (pin_edge)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  last_half_q, last_half_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        code_q, code_d;

    logic [EDGE_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]  min_q, min_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic [EDGE_W-1:0] edge_inc;

    assign cnt_inc  = sat_inc_cnt(cnt_q);
    assign edge_inc = sat_inc_edge(edge_cnt_q);

    // A limit is "reached" when the incremented count hits it, so the count
    // equals the edge-to-edge interval and an edge on that cycle still wins.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_cnt_d  = edge_cnt_q;
        last_half_d = last_half_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        code_d      = code_q;
        exp_d       = exp_q;
        min_d       = min_q;
        max_d       = max_q;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d    = ST_ARMED;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    code_d     = FC_NONE;
                    edge_cnt_d = '0;
                    exp_d      = (exp_edges == '0) ? EDGE_ONE : exp_edges;
                    min_d      = min_half;
                    max_d      = max_half;
                    tmo_d      = timeout;
                end
            end

            ST_ARMED: begin
                cnt_d = cnt_inc;
                if (pin_edge) begin
                    edge_cnt_d = EDGE_ONE;
                    cnt_d      = '0;
                    if (exp_q <= EDGE_ONE) begin
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else if (cnt_inc >= tmo_q) begin
                    fail_d  = 1'b1;
                    code_d  = FC_TIMEOUT;
                    state_d = ST_DONE;
                end
            end

            ST_MEASURE: begin
                cnt_d = cnt_inc;
                if (pin_edge) begin
                    last_half_d = cnt_inc;
                    if (cnt_inc < min_q) begin
                        fail_d  = 1'b1;
                        code_d  = FC_SHORT;
                        state_d = ST_DONE;
                    end else begin
                        edge_cnt_d = edge_inc;
                        cnt_d      = '0;
                        if (edge_inc == exp_q) begin
                            pass_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end else if (cnt_inc >= max_q) begin
                    fail_d  = 1'b1;
                    code_d  = FC_LONG;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            edge_cnt_q  <= '0;
            last_half_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            code_q      <= FC_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            last_half_q <= last_half_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
        end
    end

    // Run configuration is only meaningful once latched by start.
    always_ff @(posedge clock) begin
        exp_q <= exp_d;
        min_q <= min_d;
        max_q <= max_d;
        tmo_q <= tmo_d;
    end

    assign busy       = (state_q == ST_ARMED) || (state_q == ST_MEASURE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign edge_count = edge_cnt_q;
    assign last_half  = last_half_q;

endmodule

// File: tb/tb_gpio_toggle_checker.sv
// Directed bench for gpio_toggle_checker: expected run results are queued as
// each run is launched and compared when the checker reports done.
module tb_gpio_toggle_checker;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        pin_in = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  exp_edges = '0;
    logic [15:0] min_half = '0;
    logic [15:0] max_half = '0;
    logic [15:0] timeout = '0;
    logic        busy, done, pass, fail;
    logic [1:0]  fail_code;
    logic [7:0]  edge_count;
    logic [15:0] last_half;

    gpio_toggle_checker #(
        .SYNC_STAGES (2),
        .CNT_W       (16),
        .EDGE_W      (8)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .pin_in     (pin_in),
        .start      (start),
        .exp_edges  (exp_edges),
        .min_half   (min_half),
        .max_half   (max_half),
        .timeout    (timeout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .edge_count (edge_count),
        .last_half  (last_half)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [7:0]  ec;
        logic [15:0] lh;
        bit          chk_lh;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int passed = 0;
    int failed = 0;
    int done_pulses = 0;

    always @(negedge clock) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic p, input logic f, input logic [1:0] c,
                            input logic [7:0] ec, input logic [15:0] lh, input bit chk_lh);
        exp_t e;
        e.pass = p; e.fail = f; e.code = c; e.ec = ec; e.lh = lh; e.chk_lh = chk_lh;
        sb.push_back(e);
    endtask

    // Inputs are scrambled after the start cycle so runs depend on latching.
    task automatic do_start(input logic [7:0] e, input logic [15:0] mn,
                            input logic [15:0] mx, input logic [15:0] to);
        @(negedge clock);
        exp_edges = e; min_half = mn; max_half = mx; timeout = to; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exp_edges = 8'd1; min_half = 16'hFFFF; max_half = 16'd1; timeout = 16'd1;
    endtask

    task automatic toggle_after(input int n);
        repeat (n) @(negedge clock);
        pin_in = ~pin_in;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_code"}, fail_code, 0);
        chk({tag, "_ec"}, edge_count, 0);
        chk({tag, "_lh"}, last_half, 0);
    endtask

    task automatic finish_run(input string tag, output int cyc);
        exp_t e;
        int p0;
        p0 = done_pulses;
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
        e = sb.pop_front();
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_fail"}, fail, e.fail);
        chk({tag, "_code"}, fail_code, e.code);
        chk({tag, "_ec"}, edge_count, e.ec);
        if (e.chk_lh) chk({tag, "_lh"}, last_half, e.lh);
        repeat (3) @(negedge clock);
        chk({tag, "_pulses"}, done_pulses - p0, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int cyc;
        int p0;

        repeat (3) @(negedge clock);
        check_zero("reset");
        resetb = 1'b1;
        repeat (3) @(negedge clock);

        // Nominal: 8 edges 20 clocks apart.
        push_exp(1, 0, 2'd0, 8'd8, 16'd20, 1);
        do_start(8'd8, 16'd10, 16'd50, 16'd100);
        chk("nom_busy", busy, 1);
        toggle_after(30);
        for (int i = 0; i < 7; i++) toggle_after(20);
        finish_run("nom", cyc);

        // First-edge timeout with pin idle.
        push_exp(0, 1, 2'd1, 8'd0, 16'd0, 0);
        do_start(8'd8, 16'd10, 16'd50, 16'd100);
        finish_run("tmo", cyc);
        chk("tmo_latency", cyc, 100);

        // Half-period too short.
        push_exp(0, 1, 2'd2, 8'd2, 16'd5, 1);
        do_start(8'd8, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        toggle_after(20);
        toggle_after(5);
        finish_run("short", cyc);

        // Pin stalls after 3 edges.
        push_exp(0, 1, 2'd3, 8'd3, 16'd20, 1);
        do_start(8'd8, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        toggle_after(20);
        toggle_after(20);
        finish_run("long", cyc);

        // Edges exactly max_half apart are accepted.
        push_exp(1, 0, 2'd0, 8'd3, 16'd50, 1);
        do_start(8'd3, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        toggle_after(50);
        toggle_after(50);
        finish_run("bound", cyc);

        // exp_edges=0 behaves as 1.
        push_exp(1, 0, 2'd0, 8'd1, 16'd0, 0);
        do_start(8'd0, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        finish_run("exp0", cyc);

        // start while busy is ignored.
        push_exp(1, 0, 2'd0, 8'd4, 16'd20, 1);
        do_start(8'd4, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        toggle_after(20);
        repeat (5) @(negedge clock);
        start = 1'b1; exp_edges = 8'd1; min_half = 16'd100;
        @(negedge clock);
        start = 1'b0;
        chk("busy_restart_busy", busy, 1);
        toggle_after(14);
        toggle_after(20);
        finish_run("restart", cyc);

        // Async reset mid-MEASURE.
        do_start(8'd8, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        toggle_after(20);
        repeat (5) @(negedge clock);
        chk("rst_mid_busy", busy, 1);
        p0 = done_pulses;
        resetb = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clock);
        check_zero("rst_hold");
        resetb = 1'b1;
        repeat (6) @(negedge clock);
        chk("rst_no_done", done_pulses - p0, 0);

        // Clean run after reset.
        push_exp(1, 0, 2'd0, 8'd2, 16'd20, 1);
        do_start(8'd2, 16'd10, 16'd50, 16'd100);
        toggle_after(10);
        toggle_after(20);
        finish_run("post_rst", cyc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
